// File: rtl/input_stream_pipeline.sv
// Copies a run of words from source SRAM m1 to destination SRAM m2, with optional byte reversal and early stop.
// Define CHECKSUM_EN to add a running XOR checksum of all written words.
module input_stream_pipeline #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
)(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              swap_en,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] m1ReadAddr,
  input  logic [DATA_W-1:0] m1ReadVal,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              m2WE,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int NBYTES = DATA_W / 8;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_cnt;
  logic              r_swap;
  logic [ADDR_W:0]   r_rd_k;
  logic [ADDR_W-1:0] r_wr_k;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_val;
  logic [ADDR_W:0]   r_ww;
  // [0]: address on m1ReadAddr is a live read; [READ_LAT]: write on m2 this cycle
  logic [READ_LAT:0] vld_pipe;

  logic              w_launch;
  logic              w_issue;
  logic              w_last;
  logic              w_cap;
  logic              w_drained;
  logic [DATA_W-1:0] w_swapped;
  logic [DATA_W-1:0] w_wr_data;

  assign w_launch  = (r_state == S_IDLE) && start;
  assign w_issue   = (r_state == S_RUN) && !stop;
  assign w_last    = (r_rd_k == (r_cnt - (ADDR_W+1)'(1)));
  assign w_cap     = vld_pipe[READ_LAT-1];
  assign w_drained = (vld_pipe[READ_LAT-1:0] == '0);

  for (genvar b = 0; b < NBYTES; b++) begin : g_swap
    assign w_swapped[8*b +: 8] = m1ReadVal[DATA_W-8-8*b +: 8];
  end

  assign w_wr_data = r_swap ? w_swapped : m1ReadVal;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (word_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (stop || w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_DONE;
      S_DONE:  if (!start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_cnt     <= '0;
      r_swap    <= 1'b0;
      r_rd_k    <= '0;
      r_wr_k    <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_val  <= '0;
      r_ww      <= '0;
      vld_pipe  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      vld_pipe <= {vld_pipe[READ_LAT-1:0], w_issue};
      if (w_launch) begin
        r_src  <= src_base;
        r_dst  <= dst_base;
        r_cnt  <= word_count;
        r_swap <= swap_en;
        r_rd_k <= '0;
        r_wr_k <= '0;
        r_ww   <= '0;
      end else if (vld_pipe[READ_LAT]) begin
        r_ww <= r_ww + (ADDR_W+1)'(1);
      end
      if (w_issue) begin
        r_rd_addr <= r_src + r_rd_k[ADDR_W-1:0];
        r_rd_k    <= r_rd_k + (ADDR_W+1)'(1);
      end
      // Writes retire in issue order, so a running offset gives dst_base+k
      if (w_cap) begin
        r_wr_addr <= r_dst + r_wr_k;
        r_wr_k    <= r_wr_k + ADDR_W'(1);
        r_wr_val  <= w_wr_data;
      end
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_cksum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                r_cksum <= '0;
    else if (w_launch)         r_cksum <= '0;
    else if (vld_pipe[READ_LAT]) r_cksum <= r_cksum ^ r_wr_val;
  end

  assign checksum = r_cksum;
`endif

  assign m1ReadAddr    = r_rd_addr;
  assign m2WriteAddr   = r_wr_addr;
  assign m2WriteVal    = r_wr_val;
  assign m2WE          = vld_pipe[READ_LAT];
  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign words_written = r_ww;

endmodule

// File: tb/tb_input_stream_pipeline.sv
// Drives a READ_LAT=1 and a READ_LAT=2 instance with identical jobs; a queue scoreboard
// checks every m2 write, its read-to-write distance, and done/words_written at job end.
module tb_input_stream_pipeline;

  typedef struct {
    logic [15:0]  src;
    logic [15:0]  dst;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, stop, swap;
  logic [15:0]  src, dst;
  logic [16:0]  cnt;

  logic [15:0]  ra0, ra1, wa0, wa1;
  logic [127:0] rv0, rv1, wv0, wv1;
  logic         we0, we1, busy0, busy1, done0, done1;
  logic [16:0]  ww0, ww1;
`ifdef CHECKSUM_EN
  logic [127:0] ck0, ck1;
`endif

  logic [15:0]  rd_addr [2];
  logic [15:0]  wr_addr [2];
  logic [127:0] wr_val  [2];
  logic         wr_en   [2];
  logic         bsy     [2];
  logic         dn      [2];
  logic [16:0]  wwc     [2];
  assign rd_addr[0] = ra0;   assign rd_addr[1] = ra1;
  assign wr_addr[0] = wa0;   assign wr_addr[1] = wa1;
  assign wr_val[0]  = wv0;   assign wr_val[1]  = wv1;
  assign wr_en[0]   = we0;   assign wr_en[1]   = we1;
  assign bsy[0]     = busy0; assign bsy[1]     = busy1;
  assign dn[0]      = done0; assign dn[1]      = done1;
  assign wwc[0]     = ww0;   assign wwc[1]     = ww1;

  logic [127:0] m1mem [65536];
  int   rl [2] = '{1, 2};

  // Source SRAM models: data sampled by the DUT READ_LAT edges after the address appears
  assign rv0 = m1mem[ra0];
  always @(posedge clk) rv1 <= m1mem[ra1];

  input_stream_pipeline #(.DATA_W(128), .ADDR_W(16), .READ_LAT(1)) u_dut0 (
    .clock(clk), .rst_n(rst_n), .start(start), .stop(stop), .swap_en(swap),
    .src_base(src), .dst_base(dst), .word_count(cnt),
    .m1ReadAddr(ra0), .m1ReadVal(rv0), .m2WriteAddr(wa0), .m2WriteVal(wv0),
    .m2WE(we0), .busy(busy0), .done(done0),
`ifdef CHECKSUM_EN
    .checksum(ck0),
`endif
    .words_written(ww0)
  );

  input_stream_pipeline #(.DATA_W(128), .ADDR_W(16), .READ_LAT(2)) u_dut1 (
    .clock(clk), .rst_n(rst_n), .start(start), .stop(stop), .swap_en(swap),
    .src_base(src), .dst_base(dst), .word_count(cnt),
    .m1ReadAddr(ra1), .m1ReadVal(rv1), .m2WriteAddr(wa1), .m2WriteVal(wv1),
    .m2WE(we1), .busy(busy1), .done(done1),
`ifdef CHECKSUM_EN
    .checksum(ck1),
`endif
    .words_written(ww1)
  );

  initial forever #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   job_id = 0;
  exp_t qa[$];
  exp_t qb[$];

  function automatic void chk(string nm, int d, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = v[8*(15-b) +: 8];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every m2 write
  initial begin
    int          seen_job [2];
    int          nwr [2];
    int          first_wr [2];
    int          last_wr [2];
    logic        pdone [2];
    logic [15:0] ahist [2][8];
    exp_t        e;
    logic        got;
    seen_job = '{-1, -1};
    pdone    = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int d = 0; d < 2; d++) begin
          if (seen_job[d] != job_id) begin
            seen_job[d] = job_id;
            nwr[d] = 0; first_wr[d] = -1; last_wr[d] = -1;
          end
          ahist[d][cyc % 8] = rd_addr[d];
          if (wr_en[d]) begin
            got = (d == 0) ? (qa.size() > 0) : (qb.size() > 0);
            chk("write_pending", d, 128'(got), 128'(1));
            if (got) begin
              if (d == 0) e = qa.pop_front();
              else        e = qb.pop_front();
              chk("wr_addr", d, 128'(wr_addr[d]), 128'(e.dst));
              chk("wr_data", d, wr_val[d], e.data);
              chk("rd_addr_before_wr", d, 128'(ahist[d][(cyc - rl[d]) % 8]), 128'(e.src));
            end
            chk("we_while_done", d, 128'(dn[d]), 128'(0));
            if (first_wr[d] < 0) first_wr[d] = cyc;
            last_wr[d] = cyc;
            nwr[d]++;
          end
          if (dn[d] && !pdone[d] && last_wr[d] >= 0) begin
            chk("done_after_last_wr", d, 128'(cyc), 128'(last_wr[d] + 1));
            chk("writes_contiguous", d, 128'(last_wr[d] - first_wr[d] + 1), 128'(nwr[d]));
          end
          pdone[d] = dn[d];
        end
      end else begin
        pdone = '{1'b0, 1'b0};
      end
    end
  end

  task automatic check_zero(string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_we"}, d, 128'(wr_en[d]), 128'(0));
      chk({nm, "_done"}, d, 128'(dn[d]), 128'(0));
      chk({nm, "_busy"}, d, 128'(bsy[d]), 128'(0));
      chk({nm, "_ww"}, d, 128'(wwc[d]), 128'(0));
      chk({nm, "_wa"}, d, 128'(wr_addr[d]), 128'(0));
      chk({nm, "_wv"}, d, wr_val[d], 128'(0));
      chk({nm, "_ra"}, d, 128'(rd_addr[d]), 128'(0));
    end
`ifdef CHECKSUM_EN
    chk({nm, "_cks"}, 0, ck0, 128'(0));
    chk({nm, "_cks"}, 1, ck1, 128'(0));
`endif
  endtask

  // stop_at: RUN cycle (1-based) in which stop is raised, 0 for none
  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [16:0] n,
                         input logic sw, input int stop_at, input int hold);
    int           nexp;
    logic [127:0] ckx;
    exp_t         e;
    logic         ok;
    nexp = (stop_at > 0 && stop_at <= int'(n)) ? stop_at - 1 : int'(n);
    ckx  = '0;
    for (int k = 0; k < nexp; k++) begin
      e.src  = s + 16'(k);
      e.dst  = d + 16'(k);
      e.data = sw ? bswap(m1mem[e.src]) : m1mem[e.src];
      ckx    = ckx ^ e.data;
      qa.push_back(e);
      qb.push_back(e);
    end
    job_id++;
    src = s; dst = d; cnt = n; swap = sw; start = 1'b1;
    @(posedge clk); #1;
    // Launch values are latched; these must be ignored
    src = 16'($urandom); dst = 16'($urandom); cnt = 17'($urandom); swap = ~sw;
    ok = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      stop = (i == stop_at);
      if (done0 && done1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    stop = 1'b0;
    chk("job_reaches_done", 0, 128'(ok), 128'(1));
    for (int j = 0; j < 2; j++) begin
      chk("busy_at_done", j, 128'(bsy[j]), 128'(0));
      chk("words_written", j, 128'(wwc[j]), 128'(nexp));
    end
    chk("writes_missing", 0, 128'(qa.size()), 128'(0));
    chk("writes_missing", 1, 128'(qb.size()), 128'(0));
    qa.delete(); qb.delete();
`ifdef CHECKSUM_EN
    chk("checksum", 0, ck0, ckx);
    chk("checksum", 1, ck1, ckx);
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("done_held", 0, 128'(done0), 128'(1));
      chk("done_held", 1, 128'(done1), 128'(1));
      chk("no_rerun", 0, 128'(busy0 | busy1), 128'(0));
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_start_low", 0, 128'(done0), 128'(0));
    chk("idle_after_start_low", 1, 128'(done1), 128'(0));
  endtask

  initial begin
    int          n, sa;
    logic [15:0] rs, rd;
    for (int a = 0; a < 65536; a++) m1mem[a] = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; swap = 1'b0; src = '0; dst = '0; cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    // stop while idle must not matter
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;

    for (int k = 0; k < 8; k++) m1mem[k] = 128'(k);
    run_job(16'h0000, 16'h0010, 17'd8, 1'b0, 0, 2);
    run_job(16'h0000, 16'h0000, 17'd0, 1'b0, 0, 1);
    run_job(16'hFFFE, 16'hFFFF, 17'd4, 1'b0, 0, 0);
    m1mem[0] = 128'h00112233445566778899AABBCCDDEEFF;
    run_job(16'h0000, 16'h0200, 17'd2, 1'b1, 0, 0);
    run_job(16'h0300, 16'h0400, 17'd100, 1'b0, 5, 0);
    run_job(16'h0500, 16'h0600, 17'd6, 1'b0, 6, 0);

    // Reset in the middle of a job: everything clears at once, nothing more is written
    job_id++;
    src = 16'h1000; dst = 16'h2000; cnt = 17'd100; swap = 1'b0; start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      exp_t e;
      e.src = 16'h1000 + 16'(k); e.dst = 16'h2000 + 16'(k); e.data = m1mem[e.src];
      qa.push_back(e); qb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midjob_reset");
    qa.delete(); qb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    job_id++;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 0, 128'(we0 | busy0 | done0), 128'(0));
    chk("post_reset_idle", 1, 128'(we1 | busy1 | done1), 128'(0));

    run_job(16'(($urandom)), 16'(($urandom)), 17'd16, 1'($urandom), 0, 4);

    for (int j = 0; j < 8; j++) begin
      n  = $urandom_range(40, 1);
      sa = ($urandom_range(1, 0) == 1) ? $urandom_range(n + 2, 1) : 0;
      rs = 16'($urandom); rd = 16'($urandom);
      run_job(rs, rd, 17'(n), 1'($urandom), sa, $urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
